reg_bank_8x16: RTL

//  8-entry x 16-bit register bank with a busy scoreboard. It sits directly upstream
//  of the 8:1 16-bit read-select muxes in the decode stage.
//  - Exposes all eight registers in parallel (q0..q7) for the external mux tree.
//  - Provides two internal combinational read ports (A/B) and one write port

---
 rtl/reg_bank_8x16_if.sv | 31 +++
 rtl/reg_bank_8x16.sv | 96 +++++++++
 2 files changed

// File: rtl/reg_bank_8x16_if.sv
// Bus bundle for reg_bank_8x16: writeback, read ports, register taps and scoreboard.
// master = decode/writeback side driving requests, slave = the register bank.
interface reg_bank_8x16_if #(
    parameter int WIDTH = 16
);
    logic             we;
    logic [2:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [2:0]       raddr_a;
    logic [2:0]       raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic [WIDTH-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic             issue_valid;
    logic [2:0]       issue_rd;
    logic [7:0]       busy;
    logic             hazard_a;
    logic             hazard_b;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, issue_valid, issue_rd,
        input  rdata_a, rdata_b, q0, q1, q2, q3, q4, q5, q6, q7,
        input  busy, hazard_a, hazard_b
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, issue_valid, issue_rd,
        output rdata_a, rdata_b, q0, q1, q2, q3, q4, q5, q6, q7,
        output busy, hazard_a, hazard_b
    );
endinterface

// File: rtl/reg_bank_8x16.sv
// 8 x WIDTH register bank (r0 hardwired to zero) with a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN selects write-first read ports; default is read-old.
module reg_bank_8x16 #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_bank_8x16_if.slave   bus
);

    logic [WIDTH-1:0] regs_q    [1:7];
    logic [WIDTH-1:0] regs_view [0:7];
    logic [7:1]       wr_hit;
    logic [7:1]       issue_hit;
    logic [7:1]       busy_q;
    logic [7:1]       busy_d;
    logic [7:0]       busy_view;

    assign regs_view[0] = '0;
    assign busy_view    = {busy_q, 1'b0};

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_reg
            assign wr_hit[gi]    = bus.we          && (bus.waddr    == 3'(gi));
            assign issue_hit[gi] = bus.issue_valid && (bus.issue_rd == 3'(gi));

            // A fresh issue claims the register even if its old producer retires now.
            assign busy_d[gi] = issue_hit[gi] ? 1'b1 :
                                wr_hit[gi]    ? 1'b0 : busy_q[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= RESET_VAL;
                    busy_q[gi] <= 1'b0;
                end else begin
                    if (wr_hit[gi]) begin
                        regs_q[gi] <= bus.wdata;
                    end
                    busy_q[gi] <= busy_d[gi];
                end
            end

            assign regs_view[gi] = regs_q[gi];
        end
    endgenerate

    assign bus.q0   = regs_view[0];
    assign bus.q1   = regs_view[1];
    assign bus.q2   = regs_view[2];
    assign bus.q3   = regs_view[3];
    assign bus.q4   = regs_view[4];
    assign bus.q5   = regs_view[5];
    assign bus.q6   = regs_view[6];
    assign bus.q7   = regs_view[7];
    assign bus.busy = busy_view;

    logic             byp_a;
    logic             byp_b;
    logic [WIDTH-1:0] rdata_a_next;
    logic [WIDTH-1:0] rdata_b_next;
    logic             hazard_a_next;
    logic             hazard_b_next;

    always_comb begin
        byp_a         = 1'b0;
        byp_b         = 1'b0;
        rdata_a_next  = regs_view[bus.raddr_a];
        rdata_b_next  = regs_view[bus.raddr_b];
        hazard_a_next = busy_view[bus.raddr_a];
        hazard_b_next = busy_view[bus.raddr_b];
`ifdef REGFILE_BYPASS_EN
        // Write-first: the value being retired this cycle is forwarded and ends the stall.
        byp_a = bus.we && (bus.waddr == bus.raddr_a) && (bus.waddr != 3'd0);
        byp_b = bus.we && (bus.waddr == bus.raddr_b) && (bus.waddr != 3'd0);
        if (byp_a) begin
            rdata_a_next  = bus.wdata;
            hazard_a_next = 1'b0;
        end
        if (byp_b) begin
            rdata_b_next  = bus.wdata;
            hazard_b_next = 1'b0;
        end
`else
        byp_a = 1'b0;
        byp_b = 1'b0;
`endif
    end

    assign bus.rdata_a  = rdata_a_next;
    assign bus.rdata_b  = rdata_b_next;
    assign bus.hazard_a = hazard_a_next & ~byp_a;
    assign bus.hazard_b = hazard_b_next & ~byp_b;

endmodule
